nvdla_dbb_ot_limiter: RTL and testbench

Outstanding-transaction limiter on the NVDLA DBB AXI port, between `nvdla_large` (slave side, `s_*`) and the SoC interconnect (master side, `m_*`). It gates AR/AW address handshakes so that at most `MAX_RD_OT` read bursts and `MAX_WR_OT` write bursts are in flight. It also provides a quiesce/idle handshake for power and reset sequencing. Payload fields (addr, id, len, size, data, strb) bypass the block at top level; only handshake and `last` signals pass through it.

---
 rtl/nvdla_dbb_ot_limiter_if.sv | 29 ++
 rtl/nvdla_dbb_ot_limiter.sv | 122 ++++++++++++
 tb/tb_nvdla_dbb_ot_limiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/nvdla_dbb_ot_limiter_if.sv
// AR/AW handshake, R/B monitor and last signals seen by the DBB outstanding-transaction limiter.
// The slave modport is the limiter's view; the master modport is the surrounding logic.
interface nvdla_dbb_ot_limiter_if;
  logic s_arvalid;
  logic s_arready;
  logic m_arvalid;
  logic m_arready;
  logic s_awvalid;
  logic s_awready;
  logic m_awvalid;
  logic m_awready;
  logic r_valid;
  logic r_ready;
  logic r_last;
  logic b_valid;
  logic b_ready;

  modport slave (
    input  s_arvalid, m_arready, s_awvalid, m_awready,
    input  r_valid, r_ready, r_last, b_valid, b_ready,
    output s_arready, m_arvalid, s_awready, m_awvalid
  );

  modport master (
    output s_arvalid, m_arready, s_awvalid, m_awready,
    output r_valid, r_ready, r_last, b_valid, b_ready,
    input  s_arready, m_arvalid, s_awready, m_awvalid
  );
endinterface

// File: rtl/nvdla_dbb_ot_limiter.sv
// Outstanding read/write burst limiter with quiesce/idle handshake for the NVDLA DBB AXI port.
// Optional stall statistics are enabled by defining NVDLA_DBB_OT_STATS_EN.
module nvdla_dbb_ot_limiter #(
  parameter int unsigned MAX_RD_OT = 16,
  parameter int unsigned MAX_WR_OT = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                          core_clk,
  input  logic                          core_rst,
  input  logic                          quiesce,
  nvdla_dbb_ot_limiter_if.slave         bus,
  output logic [CNT_W-1:0]              rd_ot,
  output logic [CNT_W-1:0]              wr_ot,
  output logic                          idle,
  output logic                          ot_err,
  output logic [31:0]                   rd_stall_cnt,
  output logic [31:0]                   wr_stall_cnt
);

  localparam logic [CNT_W-1:0] RdMax = CNT_W'(MAX_RD_OT);
  localparam logic [CNT_W-1:0] WrMax = CNT_W'(MAX_WR_OT);

  logic             quiesce_q;
  logic             ar_hold_q, ar_hold_d;
  logic             aw_hold_q, aw_hold_d;
  logic [CNT_W-1:0] rd_ot_q, rd_ot_d;
  logic [CNT_W-1:0] wr_ot_q, wr_ot_d;
  logic             idle_q, idle_d;
  logic             ot_err_q, ot_err_d;

  logic ar_gate, aw_gate;
  logic ar_fire, aw_fire, rd_ret, wr_ret;

  // Held requests stay presented through quiesce so AXI valid never drops before ready.
  assign ar_gate = !core_rst && (((rd_ot_q < RdMax) && !quiesce_q) || ar_hold_q);
  assign aw_gate = !core_rst && (((wr_ot_q < WrMax) && !quiesce_q) || aw_hold_q);

  assign bus.m_arvalid = bus.s_arvalid && ar_gate;
  assign bus.s_arready = bus.m_arready && ar_gate;
  assign bus.m_awvalid = bus.s_awvalid && aw_gate;
  assign bus.s_awready = bus.m_awready && aw_gate;

  assign ar_fire = bus.m_arvalid && bus.m_arready;
  assign aw_fire = bus.m_awvalid && bus.m_awready;
  assign rd_ret  = bus.r_valid && bus.r_ready && bus.r_last;
  assign wr_ret  = bus.b_valid && bus.b_ready;

  always_comb begin
    ar_hold_d = ar_hold_q;
    aw_hold_d = aw_hold_q;
    rd_ot_d   = rd_ot_q;
    wr_ot_d   = wr_ot_q;
    ot_err_d  = ot_err_q;

    if (ar_fire)            ar_hold_d = 1'b0;
    else if (bus.m_arvalid) ar_hold_d = 1'b1;
    if (aw_fire)            aw_hold_d = 1'b0;
    else if (bus.m_awvalid) aw_hold_d = 1'b1;

    if (ar_fire && !rd_ret) begin
      rd_ot_d = rd_ot_q + 1'b1;
    end else if (!ar_fire && rd_ret) begin
      if (rd_ot_q == '0) ot_err_d = 1'b1;
      else               rd_ot_d  = rd_ot_q - 1'b1;
    end

    if (aw_fire && !wr_ret) begin
      wr_ot_d = wr_ot_q + 1'b1;
    end else if (!aw_fire && wr_ret) begin
      if (wr_ot_q == '0) ot_err_d = 1'b1;
      else               wr_ot_d  = wr_ot_q - 1'b1;
    end

    idle_d = quiesce_q && (rd_ot_d == '0) && (wr_ot_d == '0) && !ar_hold_d && !aw_hold_d;
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      quiesce_q <= 1'b0;
      ar_hold_q <= 1'b0;
      aw_hold_q <= 1'b0;
      rd_ot_q   <= '0;
      wr_ot_q   <= '0;
      idle_q    <= 1'b0;
      ot_err_q  <= 1'b0;
    end else begin
      quiesce_q <= quiesce;
      ar_hold_q <= ar_hold_d;
      aw_hold_q <= aw_hold_d;
      rd_ot_q   <= rd_ot_d;
      wr_ot_q   <= wr_ot_d;
      idle_q    <= idle_d;
      ot_err_q  <= ot_err_d;
    end
  end

  assign rd_ot  = rd_ot_q;
  assign wr_ot  = wr_ot_q;
  assign idle   = idle_q;
  assign ot_err = ot_err_q;

`ifdef NVDLA_DBB_OT_STATS_EN
  logic [31:0] rd_stall_q, wr_stall_q;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      if (bus.s_arvalid && !bus.s_arready && (rd_stall_q != '1)) rd_stall_q <= rd_stall_q + 1'b1;
      if (bus.s_awvalid && !bus.s_awready && (wr_stall_q != '1)) wr_stall_q <= wr_stall_q + 1'b1;
    end
  end

  assign rd_stall_cnt = rd_stall_q;
  assign wr_stall_cnt = wr_stall_q;
`else
  assign rd_stall_cnt = '0;
  assign wr_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nvdla_dbb_ot_limiter.sv
// Directed self-checking bench for nvdla_dbb_ot_limiter with a limit of 4 reads and 4 writes.
module tb_nvdla_dbb_ot_limiter;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        quiesce;
  logic [7:0]  rd_ot, wr_ot;
  logic        idle, ot_err;
  logic [31:0] rd_stall_cnt, wr_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int fires;

  nvdla_dbb_ot_limiter_if bus ();

  nvdla_dbb_ot_limiter #(
    .MAX_RD_OT (4),
    .MAX_WR_OT (4),
    .CNT_W     (8)
  ) dut (
    .core_clk     (core_clk),
    .core_rst     (core_rst),
    .quiesce      (quiesce),
    .bus          (bus.slave),
    .rd_ot        (rd_ot),
    .wr_ot        (wr_ot),
    .idle         (idle),
    .ot_err       (ot_err),
    .rd_stall_cnt (rd_stall_cnt),
    .wr_stall_cnt (wr_stall_cnt)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge core_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.s_arvalid = 0; bus.m_arready = 0; bus.s_awvalid = 0; bus.m_awready = 0;
    bus.r_valid = 0; bus.r_ready = 0; bus.r_last = 0; bus.b_valid = 0; bus.b_ready = 0;
  endtask

  task automatic set_r(input logic v);
    bus.r_valid = v; bus.r_ready = v; bus.r_last = v;
  endtask

  task automatic set_b(input logic v);
    bus.b_valid = v; bus.b_ready = v;
  endtask

  initial begin
    clear_inputs();
    quiesce  = 0;
    core_rst = 1;
    cycle();
    bus.s_arvalid = 1; bus.m_arready = 1; bus.s_awvalid = 1; bus.m_awready = 1;
    #1;
    check("rst_arvalid", bus.m_arvalid, 0);
    check("rst_awvalid", bus.m_awvalid, 0);
    cycle();
    clear_inputs();
    core_rst = 0;
    cycle();
    check("rst_rd_ot", rd_ot, 0);
    check("rst_wr_ot", wr_ot, 0);
    check("rst_idle", idle, 0);
    check("rst_ot_err", ot_err, 0);
    check("rst_rd_stall", rd_stall_cnt, 0);

    // Read limit: exactly four fires then blocked
    bus.s_arvalid = 1; bus.m_arready = 1;
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.m_arvalid && bus.m_arready) fires++;
      cycle();
    end
    check("lim_fires", fires, 4);
    check("lim_arready", bus.s_arready, 0);
    check("lim_rd_ot", rd_ot, 4);

    // R-last in cycle N frees a slot for cycle N+1, not N
    set_r(1);
    #1;
    check("rl_same_cycle", bus.s_arready, 0);
    cycle();
    set_r(0);
    #1;
    check("rl_next_fire", bus.m_arvalid && bus.s_arready, 1);
    check("rl_rd_ot_3", rd_ot, 3);
    cycle();
    check("rl_rd_ot_4", rd_ot, 4);
    check("rl_blocked", bus.s_arready, 0);

    // Drain to 2, then AR fire and R-last together
    bus.s_arvalid = 0;
    set_r(1);
    cycle();
    cycle();
    set_r(0);
    check("sim_pre_rd", rd_ot, 2);
    bus.s_arvalid = 1;
    set_r(1);
    #1;
    check("sim_ar_fire", bus.m_arvalid && bus.m_arready, 1);
    cycle();
    bus.s_arvalid = 0;
    set_r(0);
    check("sim_rd_ot", rd_ot, 2);

    bus.s_awvalid = 1; bus.m_awready = 1;
    cycle();
    cycle();
    check("sim_pre_wr", wr_ot, 2);
    set_b(1);
    cycle();
    bus.s_awvalid = 0; bus.m_awready = 0;
    check("sim_wr_ot", wr_ot, 2);
    cycle();
    cycle();
    set_b(0);
    check("drain_wr_ot", wr_ot, 0);
    check("no_err_yet", ot_err, 0);

    // Underflow on B with nothing outstanding
    set_b(1);
    cycle();
    set_b(0);
    check("uf_wr_ot", wr_ot, 0);
    check("uf_ot_err", ot_err, 1);
    bus.s_awvalid = 1; bus.m_awready = 1;
    cycle();
    bus.s_awvalid = 0; bus.m_awready = 0;
    check("uf_aw_wr_ot", wr_ot, 1);
    set_b(1);
    cycle();
    set_b(0);
    check("uf_b_wr_ot", wr_ot, 0);
    check("uf_sticky", ot_err, 1);

    // Quiesce while an AR is held by a stalled interconnect
    bus.s_arvalid = 1; bus.m_arready = 0;
    #1;
    check("q_present", bus.m_arvalid, 1);
    cycle();
    quiesce = 1;
    cycle();
    check("q_held_1", bus.m_arvalid, 1);
    cycle();
    check("q_held_2", bus.m_arvalid, 1);
    bus.m_arready = 1;
    #1;
    check("q_hold_fire", bus.s_arready, 1);
    cycle();
    check("q_blocked", bus.m_arvalid, 0);
    check("q_rd_ot", rd_ot, 3);
    check("q_not_idle", idle, 0);
    bus.s_arvalid = 0; bus.m_arready = 0;
    set_r(1);
    cycle();
    cycle();
    check("q_idle_early", idle, 0);
    cycle();
    set_r(0);
    check("q_drained", rd_ot, 0);
    check("q_idle", idle, 1);
    quiesce = 0;
    cycle();
    check("uq_idle_hold", idle, 1);
    cycle();
    check("uq_idle_drop", idle, 0);

    // Reset mid-operation
    bus.s_arvalid = 1; bus.m_arready = 1; bus.s_awvalid = 1; bus.m_awready = 1;
    cycle();
    cycle();
    cycle();
    bus.s_awvalid = 0;
    cycle();
    check("mr_rd_ot", rd_ot, 4);
    check("mr_wr_ot", wr_ot, 3);
    bus.s_awvalid = 1;
    core_rst = 1;
    #1;
    check("mr_arvalid", bus.m_arvalid, 0);
    check("mr_awvalid", bus.m_awvalid, 0);
    cycle();
    core_rst = 0;
    clear_inputs();
    check("mr_rd_zero", rd_ot, 0);
    check("mr_wr_zero", wr_ot, 0);
    check("mr_idle", idle, 0);
    check("mr_ot_err", ot_err, 0);

    // Stall statistics: 4 fires then 10 blocked AR cycles; AW blocked 3 cycles
    bus.s_arvalid = 1; bus.m_arready = 1;
    for (int i = 0; i < 14; i++) begin
      bus.s_awvalid = (i < 3);
      cycle();
    end
    clear_inputs();
`ifdef NVDLA_DBB_OT_STATS_EN
    check("st_rd_stall", rd_stall_cnt, 10);
    check("st_wr_stall", wr_stall_cnt, 3);
`else
    check("st_rd_stall", rd_stall_cnt, 0);
    check("st_wr_stall", wr_stall_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
